// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg: shared types and constants for the pulse_gen sequencer.
// Holds the sequencer state enum, the profile field indices and the
// prm_bus slot layout (slot k occupies bits [k*BIT_WIDTH +: BIT_WIDTH]).
package pulse_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PULSE = 3'd2,
    ST_QUIET = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Profile field indices as written through cfg_field.
  localparam int FLD_A   = 0;
  localparam int FLD_N1  = 1;
  localparam int FLD_N2  = 2;
  localparam int FLD_B   = 3;
  localparam int FLD_B1  = 4;
  localparam int FLD_B2  = 5;
  localparam int FLD_C   = 6;
  localparam int FLD_C1  = 7;
  localparam int FLD_C2  = 8;
  localparam int FLD_D   = 9;
  localparam int FLD_D1  = 10;
  localparam int FLD_D2  = 11;
  localparam int FLD_E   = 12;
  localparam int FLD_GAP = 13;

  localparam int NUM_FIELDS = 14;

  // prm_bus carries the twelve generator fields n1..E, which are stored
  // contiguously in the profile (fields 1..12), so the bus is a straight
  // slice of the profile word.
  localparam int PRM_FIELDS = 12;
  localparam int PRM_N1 = 0;
  localparam int PRM_N2 = 1;
  localparam int PRM_B  = 2;
  localparam int PRM_B1 = 3;
  localparam int PRM_B2 = 4;
  localparam int PRM_C  = 5;
  localparam int PRM_C1 = 6;
  localparam int PRM_C2 = 7;
  localparam int PRM_D  = 8;
  localparam int PRM_D1 = 9;
  localparam int PRM_D2 = 10;
  localparam int PRM_E  = 11;

  // LSB position of a prm_bus slot for a given field width.
  function automatic int prm_lsb(input int slot, input int bw);
    return slot * bw;
  endfunction

endpackage

// File: rtl/pulse_sched_regfile.sv
// pulse_sched_regfile: NUM_PROF x 14-field profile table.
// Ports: cfg_* write port (cfg_err pulses one cycle after a rejected write),
// busy/act_prof lock out the running profile, rd_idx/rd_prof full-profile read.
module pulse_sched_regfile
  import pulse_sched_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_PROF  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_PROF)-1:0]     cfg_prof,
  input  logic [3:0]                      cfg_field,
  input  logic [BIT_WIDTH-1:0]            cfg_data,
  input  logic                            busy,
  input  logic [$clog2(NUM_PROF)-1:0]     act_prof,
  input  logic [$clog2(NUM_PROF)-1:0]     rd_idx,
  output logic [NUM_FIELDS*BIT_WIDTH-1:0] rd_prof,
  output logic                            cfg_err
);

  logic [NUM_FIELDS-1:0][BIT_WIDTH-1:0] prof_q [NUM_PROF];
  logic [NUM_FIELDS-1:0][BIT_WIDTH-1:0] prof_d [NUM_PROF];
  logic cfg_err_q, cfg_err_d;
  logic fld_ok, locked, wr_ok;

  always_comb begin
    fld_ok    = (cfg_field < 4'(NUM_FIELDS));
    // The running profile's shadow is already taken, but its table entry is
    // still protected so a loop restart sees the same values.
    locked    = busy && (cfg_prof == act_prof);
    wr_ok     = cfg_we && fld_ok && !locked;
    cfg_err_d = cfg_we && !wr_ok;
    prof_d    = prof_q;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      if (wr_ok && (cfg_field == 4'(f))) begin
        prof_d[cfg_prof][f] = cfg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PROF; i++) begin
        prof_q[i] <= '0;
      end
      cfg_err_q <= 1'b0;
    end else begin
      prof_q    <= prof_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign rd_prof = prof_q[rd_idx];
  assign cfg_err = cfg_err_q;

endmodule

// File: rtl/pulse_sched.sv
// pulse_sched: sequences timing profiles into pulse_gen (pulse_in + prm_bus).
// Ports: cfg_* profile writes, start/stop/seq_len/loop_en control, gen_act
// quiet detect, pulse_in/prm_bus/act_prof to the generator, busy/done/err status.
// Optional watchdog in QUIET: define PULSE_SCHED_TIMEOUT_EN (adds TIMEOUT).
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_PROF  = 4
`ifdef PULSE_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 65535
`endif
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_PROF)-1:0]     cfg_prof,
  input  logic [3:0]                      cfg_field,
  input  logic [BIT_WIDTH-1:0]            cfg_data,
  output logic                            cfg_err,
  input  logic                            start,
  input  logic                            stop,
  input  logic [$clog2(NUM_PROF):0]       seq_len,
  input  logic                            loop_en,
  input  logic                            gen_act,
  output logic                            pulse_in,
  output logic [PRM_FIELDS*BIT_WIDTH-1:0] prm_bus,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(NUM_PROF)-1:0]     act_prof,
  output logic                            err
);

  localparam int PW = $clog2(NUM_PROF);
  localparam int FW = NUM_FIELDS * BIT_WIDTH;
  localparam int PB = PRM_FIELDS * BIT_WIDTH;
  localparam logic [PW-1:0] LAST_MAX = PW'(NUM_PROF - 1);

  state_e               state_q, state_d;
  logic [PW-1:0]        idx_q, idx_d;
  logic [BIT_WIDTH-1:0] pw_cnt_q, pw_cnt_d;
  logic [BIT_WIDTH-1:0] qt_cnt_q, qt_cnt_d;
  logic                 abort_q, abort_d;
  logic [BIT_WIDTH-1:0] a_q, a_d;
  logic [BIT_WIDTH-1:0] gap_q, gap_d;
  logic [PB-1:0]        prm_q, prm_d;
  logic [PW-1:0]        act_q, act_d;
  logic                 pulse_q, pulse_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [FW-1:0]        rd_prof;
  logic [PW:0]          len_m1;
  logic [PW-1:0]        last_idx;
  logic [BIT_WIDTH-1:0] a_last, gap_last;

`ifdef PULSE_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  pulse_sched_regfile #(
    .BIT_WIDTH (BIT_WIDTH),
    .NUM_PROF  (NUM_PROF)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_prof  (cfg_prof),
    .cfg_field (cfg_field),
    .cfg_data  (cfg_data),
    .busy      (busy_q),
    .act_prof  (act_q),
    .rd_idx    (idx_d),
    .rd_prof   (rd_prof),
    .cfg_err   (cfg_err)
  );

  // Zero lengths/widths/gaps are treated as one; seq_len is clamped to the table.
  always_comb begin
    len_m1 = (seq_len == '0) ? '0 : seq_len - 1'b1;
    if (len_m1 > {1'b0, LAST_MAX}) begin
      len_m1 = {1'b0, LAST_MAX};
    end
    last_idx = len_m1[PW-1:0];
    a_last   = (a_q == '0)   ? '0 : a_q - 1'b1;
    gap_last = (gap_q == '0) ? '0 : gap_q - 1'b1;
  end

  // Next-state process.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pw_cnt_d = '0;
    qt_cnt_d = '0;
    abort_d  = abort_q;
`ifdef PULSE_SCHED_TIMEOUT_EN
    wd_d     = '0;
    err_d    = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (!stop && start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
`ifdef PULSE_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_QUIET;
          abort_d = 1'b1;
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (stop) begin
          state_d = ST_QUIET;
          abort_d = 1'b1;
        end else if (pw_cnt_q == a_last) begin
          state_d = ST_QUIET;
        end else begin
          pw_cnt_d = pw_cnt_q + 1'b1;
        end
      end
      ST_QUIET: begin
        if (stop) begin
          abort_d = 1'b1;
        end
        // Any generator activity restarts the quiet window.
        if (gen_act) begin
          qt_cnt_d = '0;
        end else if (qt_cnt_q == gap_last) begin
          state_d = abort_d ? ST_IDLE : ST_NEXT;
        end else begin
          qt_cnt_d = qt_cnt_q + 1'b1;
        end
`ifdef PULSE_SCHED_TIMEOUT_EN
        if (gen_act) begin
          if (wd_q == WD_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
`endif
      end
      ST_NEXT: begin
        if (stop) begin
          state_d = ST_QUIET;
          abort_d = 1'b1;
        end else if (idx_q == last_idx) begin
          if (loop_en) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow capture on entry to LOAD, so prm_bus is settled during LOAD and
  // therefore a full cycle ahead of the pulse_in rise.
  always_comb begin
    prm_d = prm_q;
    a_d   = a_q;
    gap_d = gap_q;
    act_d = act_q;
    if (state_d == ST_LOAD) begin
      prm_d = rd_prof[FLD_N1*BIT_WIDTH +: PB];
      a_d   = rd_prof[FLD_A*BIT_WIDTH +: BIT_WIDTH];
      gap_d = rd_prof[FLD_GAP*BIT_WIDTH +: BIT_WIDTH];
      act_d = idx_d;
    end
  end

  // Output process: outputs are registered images of the next state.
  always_comb begin
    pulse_d = (state_d == ST_PULSE);
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      pw_cnt_q <= '0;
      qt_cnt_q <= '0;
      abort_q  <= 1'b0;
      a_q      <= '0;
      gap_q    <= '0;
      prm_q    <= '0;
      act_q    <= '0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef PULSE_SCHED_TIMEOUT_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pw_cnt_q <= pw_cnt_d;
      qt_cnt_q <= qt_cnt_d;
      abort_q  <= abort_d;
      a_q      <= a_d;
      gap_q    <= gap_d;
      prm_q    <= prm_d;
      act_q    <= act_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef PULSE_SCHED_TIMEOUT_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  assign pulse_in = pulse_q;
  assign prm_bus  = prm_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign act_prof = act_q;
`ifdef PULSE_SCHED_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: directed self-checking bench for pulse_sched.
// Cycle j = 1 is the LOAD cycle after the edge that samples start; outputs
// are sampled on the falling clock edge.
module tb_pulse_sched;
  import pulse_sched_pkg::*;

  localparam int BW = 16;
  localparam int NP = 4;
  localparam int PW = 2;

  logic              clk;
  logic              reset_n;
  logic              cfg_we;
  logic [PW-1:0]     cfg_prof;
  logic [3:0]        cfg_field;
  logic [BW-1:0]     cfg_data;
  logic              cfg_err;
  logic              start;
  logic              stop;
  logic [PW:0]       seq_len;
  logic              loop_en;
  logic              gen_act;
  logic              pulse_in;
  logic [12*BW-1:0]  prm_bus;
  logic              busy;
  logic              done;
  logic [PW-1:0]     act_prof;
  logic              err;

  int checks = 0;
  int errors = 0;

  pulse_sched #(
    .BIT_WIDTH (BW),
    .NUM_PROF  (NP)
`ifdef PULSE_SCHED_TIMEOUT_EN
    , .TIMEOUT (100)
`endif
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_prof  (cfg_prof),
    .cfg_field (cfg_field),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .start     (start),
    .stop      (stop),
    .seq_len   (seq_len),
    .loop_en   (loop_en),
    .gen_act   (gen_act),
    .pulse_in  (pulse_in),
    .prm_bus   (prm_bus),
    .busy      (busy),
    .done      (done),
    .act_prof  (act_prof),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [PW-1:0] p, input logic [3:0] f, input logic [BW-1:0] d);
    cfg_we = 1'b1; cfg_prof = p; cfg_field = f; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({pulse_in, busy, done, cfg_err, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {pulse_in, busy, done, cfg_err, err});
    end
    checks++;
    if (prm_bus !== '0 || act_prof !== '0) begin
      errors++;
      $display("FAIL reset_bus: prm_bus=%h act_prof=%0d, required 0/0", prm_bus, act_prof);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic ep, ed, eb;
    wr(0, 4'(FLD_A), 16'd5);
    wr(0, 4'(FLD_GAP), 16'd3);
    wr(0, 4'(FLD_N1), 16'h1110);
    seq_len = 3'd1; gen_act = 1'b0;
    kick();
    for (int j = 1; j <= 12; j++) begin
      ep = (j >= 2 && j <= 6);
      ed = (j == 11);
      eb = (j <= 11);
      checks++;
      if ({pulse_in, done, busy} !== {ep, ed, eb}) begin
        errors++;
        $display("FAIL single_cyc%0d: pulse/done/busy=%b, required %b", j, {pulse_in, done, busy}, {ep, ed, eb});
      end
      step();
    end
  endtask

  task automatic test_sequence();
    logic [BW-1:0] n1_exp [3];
    logic prev_p;
    int gcnt, trig, fall_t;
    logic got_done;
    n1_exp[0] = 16'h1110; n1_exp[1] = 16'h2220; n1_exp[2] = 16'h3330;
    for (int p = 0; p < 3; p++) begin
      wr(PW'(p), 4'(FLD_N1), n1_exp[p]);
      wr(PW'(p), 4'(FLD_A), 16'd2);
      wr(PW'(p), 4'(FLD_GAP), 16'd2);
    end
    wr(2, 4'(FLD_E), 16'hE2E2);
    seq_len = 3'd3; loop_en = 1'b0;
    prev_p = 1'b0; gcnt = 0; trig = 0; fall_t = 0; got_done = 1'b0;
    kick();
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (pulse_in && !prev_p) begin
        checks++;
        if (trig > 2 || act_prof !== PW'(trig) || prm_bus[15:0] !== n1_exp[trig % 3]) begin
          errors++;
          $display("FAIL seq_trig%0d: act_prof=%0d n1=%h, required %0d/%h", trig, act_prof, prm_bus[15:0], trig, n1_exp[trig % 3]);
        end
        if (trig > 0) begin
          checks++;
          if (cyc - fall_t != 24) begin
            errors++;
            $display("FAIL seq_spacing%0d: fall-to-rise %0d cycles, required 24", trig, cyc - fall_t);
          end
        end
        if (trig == 2) begin
          checks++;
          if (prm_bus[PRM_E*BW +: BW] !== 16'hE2E2) begin
            errors++;
            $display("FAIL seq_e_slot: got %h, required e2e2", prm_bus[PRM_E*BW +: BW]);
          end
        end
        trig++;
      end
      if (!pulse_in && prev_p) begin
        fall_t = cyc;
        gcnt = 20;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      gen_act = (gcnt > 0);
      if (gcnt > 0) gcnt--;
      prev_p = pulse_in;
      step();
    end
    gen_act = 1'b0;
    checks++;
    if (trig != 3 || got_done !== 1'b1) begin
      errors++;
      $display("FAIL seq_end: triggers=%0d done=%b, required 3/1", trig, got_done);
    end
    step();
  endtask

  task automatic test_loop_stop();
    logic prev_p, done_seen, stopped;
    int trig;
    wr(0, 4'(FLD_A), 16'd4);
    wr(1, 4'(FLD_A), 16'd4);
    seq_len = 3'd2; loop_en = 1'b1; gen_act = 1'b0;
    prev_p = 1'b0; done_seen = 1'b0; stopped = 1'b0; trig = 0;
    kick();
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done) done_seen = 1'b1;
      if (pulse_in && !prev_p) begin
        checks++;
        if (act_prof !== PW'(trig % 2)) begin
          errors++;
          $display("FAIL loop_order%0d: act_prof=%0d, required %0d", trig, act_prof, trig % 2);
        end
        trig++;
        if (trig == 4) begin
          stop = 1'b1;
          step();
          stop = 1'b0;
          checks++;
          if ({pulse_in, busy} !== 2'b01) begin
            errors++;
            $display("FAIL stop_drop: pulse/busy=%b, required 01", {pulse_in, busy});
          end
          step();
          checks++;
          if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL stop_quiet: busy/done=%b, required 10", {busy, done});
          end
          step();
          checks++;
          if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL stop_idle: busy/done=%b, required 00", {busy, done});
          end
          stopped = 1'b1;
          break;
        end
      end
      prev_p = pulse_in;
      step();
    end
    loop_en = 1'b0;
    checks++;
    if (stopped !== 1'b1 || done_seen !== 1'b0) begin
      errors++;
      $display("FAIL loop_end: stopped=%b done_seen=%b, required 1/0", stopped, done_seen);
    end
    step();
  endtask

  task automatic test_cfg_err();
    seq_len = 3'd1; gen_act = 1'b1;
    kick();
    wr(0, 4'(FLD_N1), 16'hDEAD);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_locked: cfg_err=%b, required 1", cfg_err);
    end
    step();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_width: cfg_err=%b, required 0", cfg_err);
    end
    wr(1, 4'(FLD_N1), 16'h2221);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_other_prof: cfg_err=%b, required 0", cfg_err);
    end
    gen_act = 1'b0;
    wait_idle("cfg_idle1");
    wr(0, 4'd14, 16'h1234);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_field14: cfg_err=%b, required 1", cfg_err);
    end
    step();
    wr(0, 4'd15, 16'h1234);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_field15: cfg_err=%b, required 1", cfg_err);
    end
    kick();
    checks++;
    if (prm_bus[15:0] !== 16'h1110) begin
      errors++;
      $display("FAIL cfg_unchanged: n1=%h, required 1110", prm_bus[15:0]);
    end
    wait_idle("cfg_idle2");
  endtask

  task automatic test_zero();
    logic ep, ed, eb;
    wr(0, 4'(FLD_A), 16'd0);
    wr(0, 4'(FLD_GAP), 16'd0);
    seq_len = 3'd0; gen_act = 1'b0;
    kick();
    for (int j = 1; j <= 6; j++) begin
      ep = (j == 2);
      ed = (j == 5);
      eb = (j <= 5);
      checks++;
      if ({pulse_in, done, busy} !== {ep, ed, eb} || act_prof !== '0) begin
        errors++;
        $display("FAIL zero_cyc%0d: pulse/done/busy=%b act=%0d, required %b/0", j, {pulse_in, done, busy}, act_prof, {ep, ed, eb});
      end
      step();
    end
  endtask

`ifdef PULSE_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic done_seen;
    done_seen = 1'b0;
    wr(0, 4'(FLD_A), 16'd1);
    wr(0, 4'(FLD_GAP), 16'd1);
    seq_len = 3'd1; gen_act = 1'b1;
    kick();
    for (int j = 1; j <= 103; j++) begin
      if (done) done_seen = 1'b1;
      if (j == 102) begin
        checks++;
        if ({err, busy} !== 2'b01) begin
          errors++;
          $display("FAIL wdog_pre: err/busy=%b, required 01", {err, busy});
        end
      end
      if (j == 103) begin
        checks++;
        if ({err, busy} !== 2'b10) begin
          errors++;
          $display("FAIL wdog_fire: err/busy=%b, required 10", {err, busy});
        end
      end
      if (j < 103) step();
    end
    gen_act = 1'b0;
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL wdog_done: done seen, required none");
    end
    kick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_clear: err=%b, required 0", err);
    end
    wait_idle("wdog_idle");
  endtask
`endif

  task automatic test_reset_mid();
    wr(0, 4'(FLD_A), 16'd6);
    wr(0, 4'(FLD_N1), 16'hABCD);
    seq_len = 3'd1; gen_act = 1'b0;
    kick();
    step();
    step();
    checks++;
    if (pulse_in !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: pulse_in=%b, required 1", pulse_in);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({pulse_in, busy, done, cfg_err} !== 4'b0 || prm_bus !== '0 || act_prof !== '0) begin
      errors++;
      $display("FAIL rstmid_async: flags=%b prm=%h act=%0d, required 0", {pulse_in, busy, done, cfg_err}, prm_bus, act_prof);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    kick();
    checks++;
    if (prm_bus !== '0) begin
      errors++;
      $display("FAIL rstmid_table: prm_bus=%h, required 0", prm_bus);
    end
    wait_idle("rstmid_idle");
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_prof = '0; cfg_field = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; seq_len = 3'd1; loop_en = 1'b0; gen_act = 1'b0;
    test_reset();
    test_single();
    test_sequence();
    test_loop_stop();
    test_cfg_err();
    test_zero();
`ifdef PULSE_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
